int_requester: RTL and testbench

INT_REQUESTER -- requirements
Module: int_requester

---
 rtl/int_requester.sv | 154 +++++++++++++++
 tb/tb_int_requester.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/int_requester.sv
// Handshaking requester: raises EQL towards an external handler, walks the
// SYNC/ASSERT/HOLD/RELEASE exchange with a shared wait timeout, and runs a compare counter.
module int_requester (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       REQ,
    input  logic       KIND,
    input  logic [3:0] LIMIT,
    input  logic [1:0] CC_MUX,
    input  logic [1:0] USCITE,
    input  logic       ENABLE_COUNT,
    input  logic       ACKOUT,
    output logic       EQL,
    output logic       CONT_EQL,
    output logic [3:0] COUNT,
    output logic       BUSY,
    output logic       DONE,
    output logic       TIMEOUT,
    output logic       PROT_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ASSERT,
        HOLD,
        RELEASE
    } state_t;

    state_t     state;
    logic       kind_q;
    logic [3:0] wait_cnt;
    logic [3:0] wait_inc;
    logic       timeout_hit;
    logic       hold_cnt;
    logic [3:0] count_next;

    // Enable requests wait for the handler's intr code, interrupts for nop/enin.
    function automatic logic sync_hit(input logic kind, input logic [1:0] cc);
        return kind ? (cc == 2'b01) : (cc == 2'b10);
    endfunction

    function automatic logic release_hit(input logic kind, input logic [1:0] cc,
                                         input logic [1:0] us);
        return kind ? ({cc, us} == 4'b1011) : ({cc, us} == 4'b0101);
    endfunction

    assign wait_inc    = wait_cnt + 4'd1;
    assign timeout_hit = (wait_inc == 4'd15);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            kind_q   <= 1'b0;
            wait_cnt <= 4'd0;
            hold_cnt <= 1'b0;
            EQL      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    EQL <= 1'b0;
                    if (REQ) begin
                        kind_q   <= KIND;
                        wait_cnt <= 4'd0;
                        state    <= SYNC;
                        BUSY     <= 1'b1;
                    end
                end
                SYNC: begin
                    wait_cnt <= wait_inc;
                    if (timeout_hit) begin
                        TIMEOUT <= 1'b1;
                        EQL     <= 1'b0;
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                    end else if (sync_hit(kind_q, CC_MUX)) begin
                        EQL   <= 1'b1;
                        state <= ASSERT;
                    end
                end
                ASSERT: begin
                    wait_cnt <= wait_inc;
                    if (timeout_hit) begin
                        TIMEOUT <= 1'b1;
                        EQL     <= 1'b0;
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                    end else if (CC_MUX == 2'b11) begin
                        wait_cnt <= 4'd0;
                        hold_cnt <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // Two cycles in HOLD keep EQL up; the wait counter is frozen here.
                    if (hold_cnt) begin
                        EQL   <= 1'b0;
                        state <= RELEASE;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                RELEASE: begin
                    wait_cnt <= wait_inc;
                    if (timeout_hit) begin
                        TIMEOUT <= 1'b1;
                        EQL     <= 1'b0;
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                    end else if (release_hit(kind_q, CC_MUX, USCITE)) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    EQL   <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        count_next = COUNT;
        if (ENABLE_COUNT && (COUNT != LIMIT)) begin
            count_next = COUNT + 4'd1;
        end else if ((COUNT == LIMIT) && !ENABLE_COUNT) begin
            count_next = 4'd0;
        end
    end

    // Counter and protocol monitor run independently of the FSM.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            COUNT    <= 4'd0;
            CONT_EQL <= 1'b0;
            PROT_ERR <= 1'b0;
        end else begin
            COUNT    <= count_next;
            CONT_EQL <= (count_next == LIMIT);
            if ((ENABLE_COUNT != ACKOUT) || (USCITE == 2'b10)) begin
                PROT_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_requester.sv
// Randomized bench for int_requester: transactions are predicted from their
// phase delays; the counter and protocol flag follow a per-cycle rule model.
module tb_int_requester;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       REQ;
    logic       KIND;
    logic [3:0] LIMIT;
    logic [1:0] CC_MUX;
    logic [1:0] USCITE;
    logic       ENABLE_COUNT;
    logic       ACKOUT;
    logic       EQL;
    logic       CONT_EQL;
    logic [3:0] COUNT;
    logic       BUSY;
    logic       DONE;
    logic       TIMEOUT;
    logic       PROT_ERR;

    int checks = 0;
    int fails  = 0;

    logic [3:0] m_count = 4'd0;
    logic       m_cont  = 1'b0;
    logic       m_prot  = 1'b0;

    always #5 clock = ~clock;

    int_requester dut (
        .clock(clock), .reset_n(reset_n), .REQ(REQ), .KIND(KIND), .LIMIT(LIMIT),
        .CC_MUX(CC_MUX), .USCITE(USCITE), .ENABLE_COUNT(ENABLE_COUNT), .ACKOUT(ACKOUT),
        .EQL(EQL), .CONT_EQL(CONT_EQL), .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE),
        .TIMEOUT(TIMEOUT), .PROT_ERR(PROT_ERR)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the counter/protocol model from the sampled inputs, then check.
    task automatic step();
        @(posedge clock);
        if (!reset_n) begin
            m_count = 4'd0;
            m_cont  = 1'b0;
            m_prot  = 1'b0;
        end else begin
            if (ENABLE_COUNT && m_count != LIMIT) m_count = m_count + 4'd1;
            else if (m_count == LIMIT && !ENABLE_COUNT) m_count = 4'd0;
            m_cont = (m_count == LIMIT);
            if (ENABLE_COUNT != ACKOUT || USCITE == 2'b10) m_prot = 1'b1;
        end
        #1;
        chk("count", 8'(COUNT), 8'(m_count));
        chk("cont_eql", 8'(CONT_EQL), 8'(m_cont));
        chk("prot_err", 8'(PROT_ERR), 8'(m_prot));
    endtask

    function automatic logic [1:0] legal_us();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // ds/da/dr: wrong codes offered before the right one in SYNC, ASSERT and RELEASE.
    task automatic run_txn(input logic kind, input int ds, input int da, input int dr);
        int s, a, r, h, rise, fall, endn;
        logic done_exp;
        logic [1:0] right_sync, c, u;
        logic [3:0] target;
        s = ds + 1; a = da + 1; r = dr + 1;
        rise = -1; fall = -1; h = 0;
        if (s >= 15) begin
            endn = 15; done_exp = 1'b0;
        end else if (s + a >= 15) begin
            rise = s; fall = 15; endn = 15; done_exp = 1'b0;
        end else begin
            rise = s; h = s + a + 2; fall = h;
            if (r >= 15) begin endn = h + 15; done_exp = 1'b0; end
            else begin endn = h + r; done_exp = 1'b1; end
        end
        right_sync = kind ? 2'b01 : 2'b10;
        target     = kind ? 4'b1011 : 4'b0101;

        chk("idle_busy", 8'(BUSY), 8'd0);
        REQ = 1'b1; KIND = kind; CC_MUX = 2'b00; USCITE = 2'b00;
        step();
        chk("start_busy", 8'(BUSY), 8'd1);
        chk("start_eql", 8'(EQL), 8'd0);
        for (int n = 1; n <= endn + 1; n++) begin
            REQ  = (n <= endn) ? 1'($urandom_range(0, 1)) : 1'b0;
            KIND = 1'($urandom_range(0, 1));
            u = legal_us();
            if (n < s) begin
                do c = 2'($urandom_range(0, 3)); while (c == right_sync);
            end else if (n == s) begin
                c = right_sync;
            end else if (n < s + a) begin
                c = 2'($urandom_range(0, 2));
            end else if (n == s + a) begin
                c = 2'b11;
            end else if (n <= s + a + 2) begin
                c = 2'($urandom_range(0, 3));
            end else if (n - h < r) begin
                do begin
                    c = 2'($urandom_range(0, 3));
                    u = legal_us();
                end while ({c, u} == target);
            end else begin
                c = target[3:2]; u = target[1:0];
            end
            CC_MUX = c; USCITE = u;
            step();
            chk("eql", 8'(EQL), 8'((rise >= 0 && n >= rise && n < fall) ? 1 : 0));
            chk("busy", 8'(BUSY), 8'((n < endn) ? 1 : 0));
            chk("done", 8'(DONE), 8'((done_exp && n == endn) ? 1 : 0));
            chk("timeout", 8'(TIMEOUT), 8'((!done_exp && n == endn) ? 1 : 0));
        end
        REQ = 1'b0; CC_MUX = 2'b00; USCITE = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0; REQ = 1'b0; KIND = 1'b0; LIMIT = 4'd0;
        CC_MUX = 2'b00; USCITE = 2'b00; ENABLE_COUNT = 1'b0; ACKOUT = 1'b0;
        step();
        step();
        chk("rst_eql", 8'(EQL), 8'd0);
        chk("rst_busy", 8'(BUSY), 8'd0);
        chk("rst_done", 8'(DONE), 8'd0);
        chk("rst_timeout", 8'(TIMEOUT), 8'd0);
        reset_n = 1'b1;
        step();

        // Directed enable and interrupt handshakes, then the timeout corners.
        run_txn(1'b0, 1, 0, 0);
        run_txn(1'b1, 0, 0, 0);
        run_txn(1'b0, 20, 0, 0);
        run_txn(1'b1, 14, 0, 0);
        run_txn(1'b0, 13, 0, 0);
        run_txn(1'b0, 5, 9, 0);
        run_txn(1'b1, 2, 2, 14);
        run_txn(1'b0, 2, 2, 13);
        for (int i = 0; i < 12; i++) begin
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 10)));
        end

        // Reset while in HOLD, then a clean transaction.
        REQ = 1'b1; KIND = 1'b0; CC_MUX = 2'b00;
        step();
        REQ = 1'b0; CC_MUX = 2'b10;
        step();
        CC_MUX = 2'b11;
        step();
        chk("hold_eql", 8'(EQL), 8'd1);
        reset_n = 1'b0; CC_MUX = 2'b01; USCITE = 2'b01;
        step();
        chk("rsthold_eql", 8'(EQL), 8'd0);
        chk("rsthold_busy", 8'(BUSY), 8'd0);
        chk("rsthold_done", 8'(DONE), 8'd0);
        chk("rsthold_timeout", 8'(TIMEOUT), 8'd0);
        reset_n = 1'b1;
        step();
        chk("rsthold_done2", 8'(DONE), 8'd0);
        chk("rsthold_idle", 8'(BUSY), 8'd0);
        CC_MUX = 2'b00; USCITE = 2'b00;
        run_txn(1'b0, 0, 1, 2);

        // Counter: directed count to LIMIT=3, then random enable/limit traffic.
        LIMIT = 4'd3; ENABLE_COUNT = 1'b0; ACKOUT = 1'b0;
        step();
        ENABLE_COUNT = 1'b1; ACKOUT = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("cnt_at_limit", 8'(COUNT), 8'd3);
        chk("cont_at_limit", 8'(CONT_EQL), 8'd1);
        ENABLE_COUNT = 1'b0; ACKOUT = 1'b0;
        step();
        chk("cnt_cleared", 8'(COUNT), 8'd0);
        chk("cont_cleared", 8'(CONT_EQL), 8'd0);
        for (int i = 0; i < 80; i++) begin
            ENABLE_COUNT = ($urandom_range(0, 3) != 0);
            ACKOUT = ENABLE_COUNT;
            if ($urandom_range(0, 7) == 0) LIMIT = 4'($urandom_range(0, 15));
            step();
        end

        // Protocol flag: illegal status, then enable/ack disagreement.
        ENABLE_COUNT = 1'b0; ACKOUT = 1'b0; USCITE = 2'b10;
        step();
        chk("prot_set_us", 8'(PROT_ERR), 8'd1);
        USCITE = 2'b00;
        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        ENABLE_COUNT = 1'b1; ACKOUT = 1'b0;
        step();
        chk("prot_set_ack", 8'(PROT_ERR), 8'd1);
        ACKOUT = 1'b1;
        step();
        run_txn(1'b1, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
